wm8731_i2c_responder: RTL and testbench
=======================================

Name: wm8731_i2c_responder

Overview:
- Synthesizable I2C target that models the WM8731 control port.
- Acts as the responder for the codec-init I2C initiator. It decodes 3-byte write frames (device address, register address + data MSB, data LSB), ACKs them, and stores 9-bit values in a 16-entry register file.
- Used in codec-config self-check and simulation, and exposes the committed configuration to the rest of the design.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address (WM8731 with CSB=0).
- SYNC_STAGES, 2, synchronizer flops on SCL/SDA (minimum 2).

Ports:
- i_clk  in  1  system clock; must be at least 20x SCL frequency.
- i_rst  in  1  synchronous active-high reset.
- i_scl  in  1  I2C clock, asynchronous.
- i_sda  in  1  resolved I2C data line, asynchronous.
- o_sda_oe  out  1  1 = pull SDA low (ACK); 0 = release.
- o_busy  out  1  high from START detection until STOP, or until the frame is abandoned to S_IGNORE.
- o_wr_valid  out  1  one-cycle pulse when a register write commits.
- o_wr_addr  out  7  register address of the committed write.
- o_wr_data  out  9  data of the committed write.
- i_rd_addr  in  4  register-file read address.
- o_rd_data  out  9  combinational read of regfile[i_rd_addr].
- o_xfer_cnt  out  8  committed-write count, saturates at 255.
- o_err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (i_rst high at a clock edge):
  - All outputs 0 except o_rd_data, which reflects the cleared file.
  - Regfile cleared to 9'h000, state S_IDLE, synchronizers loaded with 1.
  - Reset mid-frame abandons the frame with no ACK and no commit.
- Input conditioning:
  - SCL and SDA pass through SYNC_STAGES flops plus one history flop.
  - Pin-to-event latency is SYNC_STAGES+1 cycles.
  - Events:
    - START: SDA falls while SCL high.
    - STOP: SDA rises while SCL high.
    - SCL rise and SCL fall edges.
- Bit handling:
  - Data bits are sampled on SCL rise, MSB first, into an 8-bit shift register with a 3-bit bit counter.
  - The byte is complete on the SCL fall after the 8th rise.
- FSM states: S_IDLE, S_ADDR, S_ACK_ADDR, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE.
- Transitions:
  - START from any state goes to S_ADDR and clears the bit counter.
    - A repeated START mid-frame discards the partial frame. If the prior frame had reached S_BYTE1 or later without committing, o_err pulses.
  - S_ADDR, byte complete:
    - If byte[7:1]==DEV_ADDR and byte[0]==0 (write), go to S_ACK_ADDR.
    - Otherwise go to S_IGNORE with no ACK. A read request (R/W=1) also pulses o_err.
  - S_ACK*:
    - o_sda_oe is set in the cycle the byte-complete SCL fall is detected.
    - It is cleared on the next SCL fall (end of the 9th clock), then the FSM advances.
    - Transitions: S_ACK_ADDR→S_BYTE1, S_ACK1→S_BYTE2, S_ACK2→S_IGNORE.
  - S_BYTE1 byte complete: latch reg_addr=byte[7:1], data_msb=byte[0].
  - S_BYTE2 byte complete:
    - data={data_msb, byte}.
    - Commit in that same cycle (o_wr_valid, o_wr_addr, o_wr_data registered, valid next cycle), then go to S_ACK2.
  - S_IGNORE: o_sda_oe=0. A 4th data byte after ACK2 is not ACKed and pulses o_err once at its completion.
  - STOP from any state goes to S_IDLE and clears o_sda_oe.
    - A STOP before the S_BYTE2 commit, while in S_ACK_ADDR..S_BYTE2, pulses o_err.
- Commit rules:
  - reg_addr 0x00–0x0E: regfile[reg_addr[3:0]] <= data; o_wr_valid=1; o_xfer_cnt increments (saturating).
  - reg_addr 0x0F (reset register): all 16 entries <= 0; o_wr_valid=1; count increments.
  - reg_addr ≥ 0x10: byte is still ACKed, no file write, no o_wr_valid, o_err pulses.
- o_wr_addr and o_wr_data hold their last committed values between pulses.
- Simultaneous events: if a START/STOP and an SCL edge are detected in the same cycle, the START/STOP wins.

Test Plan:
- Write R4 = 9'h012: START, bytes 0x34, 0x08, 0x12, STOP. Required: o_sda_oe high during all three 9th clocks; o_wr_valid pulse with o_wr_addr=7'h04, o_wr_data=9'h012; i_rd_addr=4 gives 9'h012; o_xfer_cnt=1; o_err never pulses.
- Data MSB: write bytes 0x34, 0x11, 0x00. Required: regfile[8]=9'h100.
- Wrong address 0x36, or read request 0x35. Required: o_sda_oe stays 0 for the whole frame; no commit. The 0x35 case gives one o_err pulse.
- Reset register: preload R2=0x079 and R6=0x000, then write 0x34, 0x1E, 0x00. Required: all entries read 0; o_wr_valid pulses with addr 0x0F; count increments.
- Abort cases:
  - STOP after byte 0x08 gives o_err, no commit, file unchanged.
  - Repeated START then a full valid frame gives only the second frame committed.
  - i_rst asserted mid-BYTE2 gives o_sda_oe=0, count=0.
- Saturation and extra byte: 260 valid writes give o_xfer_cnt=255. A 4-byte frame gives the 4th byte NACKed and one o_err pulse, while the 3-byte commit still occurs.

Source files
------------

// File: rtl/wm8731_i2c_responder_if.sv
// wm8731_i2c_responder_if: I2C pins plus the committed-write strobe of the WM8731 responder
interface wm8731_i2c_responder_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oe;
  logic       o_wr_valid;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data;
  modport master (output i_scl, i_sda, input o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data);
  modport slave  (input i_scl, i_sda, output o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data);
endinterface

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: I2C write-only target modelling the WM8731 control port and its 16x9 register file
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  wm8731_i2c_responder_if.slave bus,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic [7:0] o_xfer_cnt,
  output logic       o_busy,
  output logic       o_err
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACK_ADDR, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES:0] scl_q, scl_d, sda_q, sda_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       full_q, full_d, extra_q, extra_d, oe_q, oe_d, msb_q, msb_d;
  logic [7:0] shift_q, shift_d, cnt_q, cnt_d;
  logic [6:0] reg_addr_q, reg_addr_d, wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d, data9;
  logic       wr_valid_q, wr_valid_d, err_q, err_d;
  logic [8:0] rf_q [16];
  logic [8:0] rf_d [16];
  logic scl_s, scl_h, sda_s, sda_h, start, stop, scl_rise, scl_fall, in_byte;
  // top bit of each chain is the history flop used for edge detection
  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign scl_h    = scl_q[SYNC_STAGES];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign sda_h    = sda_q[SYNC_STAGES];
  assign start    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop     = scl_s & scl_h & ~sda_h & sda_s;
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign in_byte  = state_q inside {S_ADDR, S_BYTE1, S_BYTE2, S_IGNORE};
  assign data9    = {msb_q, shift_q};
  always_comb begin
    scl_d      = {scl_q[SYNC_STAGES-1:0], bus.i_scl};
    sda_d      = {sda_q[SYNC_STAGES-1:0], bus.i_sda};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    full_d     = full_q;
    extra_d    = extra_q;
    oe_d       = oe_q;
    msb_d      = msb_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    reg_addr_d = reg_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    err_d      = 1'b0;
    rf_d       = rf_q;
    if (start) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      full_d    = 1'b0;
      oe_d      = 1'b0;
      extra_d   = 1'b0;
      err_d     = state_q inside {S_BYTE1, S_ACK1, S_BYTE2};
    end else if (stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      extra_d = 1'b0;
      err_d   = state_q inside {S_ACK_ADDR, S_BYTE1, S_ACK1, S_BYTE2};
    end else if (scl_rise && in_byte) begin
      shift_d   = {shift_q[6:0], sda_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      full_d    = full_q | (bit_cnt_q == 3'd7);
    end else if (scl_fall) begin
      if (full_q) begin
        bit_cnt_d = '0;
        full_d    = 1'b0;
      end
      case (state_q)
        S_ADDR: if (full_q) begin
          oe_d    = shift_q[7:1] == DEV_ADDR && !shift_q[0];
          state_d = oe_d ? S_ACK_ADDR : S_IGNORE;
          err_d   = shift_q[0];
        end
        S_BYTE1: if (full_q) begin
          reg_addr_d = shift_q[7:1];
          msb_d      = shift_q[0];
          oe_d       = 1'b1;
          state_d    = S_ACK1;
        end
        S_BYTE2: if (full_q) begin
          if (reg_addr_q <= 7'h0E) rf_d[reg_addr_q[3:0]] = data9;
          else if (reg_addr_q == 7'h0F) rf_d = '{default: '0};
          wr_valid_d = reg_addr_q <= 7'h0F;
          err_d      = !wr_valid_d;
          wr_addr_d  = wr_valid_d ? reg_addr_q : wr_addr_q;
          wr_data_d  = wr_valid_d ? data9 : wr_data_q;
          cnt_d      = cnt_q + {7'd0, wr_valid_d && cnt_q != 8'hFF};
          oe_d       = 1'b1;
          state_d    = S_ACK2;
        end
        S_IGNORE: if (full_q) begin
          err_d   = extra_q;
          extra_d = 1'b0;
        end
        S_ACK_ADDR: begin
          oe_d    = 1'b0;
          state_d = S_BYTE1;
        end
        S_ACK1: begin
          oe_d    = 1'b0;
          state_d = S_BYTE2;
        end
        S_ACK2: begin
          oe_d    = 1'b0;
          extra_d = 1'b1;
          state_d = S_IGNORE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_q      <= '1;
      sda_q      <= '1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      full_q     <= 1'b0;
      extra_q    <= 1'b0;
      oe_q       <= 1'b0;
      msb_q      <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      reg_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rf_q       <= '{default: '0};
    end else begin
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      full_q     <= full_d;
      extra_q    <= extra_d;
      oe_q       <= oe_d;
      msb_q      <= msb_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      reg_addr_q <= reg_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      err_q      <= err_d;
      rf_q       <= rf_d;
    end
  end
  assign bus.o_sda_oe   = oe_q;
  assign bus.o_wr_valid = wr_valid_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;
  assign o_rd_data      = rf_q[i_rd_addr];
  assign o_xfer_cnt     = cnt_q;
  assign o_busy         = state_q != S_IDLE && state_q != S_IGNORE;
  assign o_err          = err_q;
endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// tb_wm8731_i2c_responder: directed I2C frames with a write scoreboard and register-file model
module tb_wm8731_i2c_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [3:0] rd_addr = '0;
  logic [8:0] rd_data;
  logic [7:0] xfer_cnt;
  logic busy, err;
  always #5 clk = ~clk;
  wm8731_i2c_responder_if bus();
  assign bus.i_scl = m_scl;
  assign bus.i_sda = m_sda & ~bus.o_sda_oe;
  wm8731_i2c_responder dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_xfer_cnt(xfer_cnt), .o_busy(busy), .o_err(err)
  );
  int tests = 0, fails = 0, q = 5, err_seen = 0, exp_err = 0, exp_cnt = 0;
  logic [15:0] exp_q [$];
  logic [8:0] mrf [16];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (err) err_seen++;
    if (bus.o_wr_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", bus.o_wr_addr, bus.o_wr_data);
      end else check("wr_commit", {bus.o_wr_addr, bus.o_wr_data}, exp_q.pop_front());
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; hold(q);
    m_scl = 1'b1; hold(q);
    m_sda = 1'b0; hold(q);
    m_scl = 1'b0; hold(q);
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; hold(q);
    m_scl = 1'b1; hold(q);
    m_sda = 1'b1; hold(q);
  endtask
  task automatic bit_out(input logic b, output logic s);
    m_sda = b; hold(q);
    m_scl = 1'b1; hold(q);
    s = bus.i_sda; hold(q);
    m_scl = 1'b0; hold(q);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, s);
    check(name, !s, exp_ack);
  endtask
  task automatic commit_model(input logic [6:0] ra, input logic [8:0] d);
    if (ra <= 7'h0F) begin
      if (ra == 7'h0F) foreach (mrf[i]) mrf[i] = '0;
      else mrf[ra[3:0]] = d;
      exp_q.push_back({ra, d});
      if (exp_cnt < 255) exp_cnt++;
    end else exp_err++;
  endtask
  task automatic frame(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
    logic ok;
    ok = a == 8'h34;
    i2c_start();
    send_byte(a, ok, "ack_dev");
    if (a[0]) exp_err++;
    if (ok) check("busy_mid", busy, 1);
    send_byte(r, ok, "ack_reg");
    if (ok) commit_model(r[7:1], {r[0], d});
    send_byte(d, ok, "ack_data");
    i2c_stop();
  endtask
  task automatic checkpoint(input string name);
    hold(10);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_err"}, err_seen, exp_err);
    check({name, "_cnt"}, xfer_cnt, exp_cnt);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1 check($sformatf("%s_rf%0d", name, i), rd_data, mrf[i]);
    end
  endtask
  initial begin
    logic s;
    foreach (mrf[i]) mrf[i] = '0;
    hold(5);
    rst = 1'b0;
    hold(5);
    check("rst_busy", busy, 0);
    check("rst_oe", bus.o_sda_oe, 0);
    check("rst_wr_valid", bus.o_wr_valid, 0);
    check("rst_wr_addr", bus.o_wr_addr, 0);
    checkpoint("reset");
    frame(8'h34, 8'h08, 8'h12);
    check("r4_wr_addr", bus.o_wr_addr, 7'h04);
    check("r4_wr_data", bus.o_wr_data, 9'h012);
    checkpoint("r4");
    frame(8'h34, 8'h11, 8'h00);
    checkpoint("msb");
    frame(8'h36, 8'h08, 8'h55);
    frame(8'h35, 8'h08, 8'h55);
    checkpoint("badaddr");
    frame(8'h34, 8'h04, 8'h79);
    frame(8'h34, 8'h0C, 8'h00);
    checkpoint("preload");
    frame(8'h34, 8'h1E, 8'h00);
    checkpoint("resetreg");
    frame(8'h34, 8'h20, 8'h55);
    checkpoint("highaddr");
    i2c_start();
    send_byte(8'h34, 1'b1, "abort_dev");
    send_byte(8'h08, 1'b1, "abort_reg");
    i2c_stop();
    exp_err++;
    checkpoint("abort_stop");
    i2c_start();
    send_byte(8'h34, 1'b1, "rs_dev");
    send_byte(8'h0A, 1'b1, "rs_reg");
    exp_err++;
    frame(8'h34, 8'h0A, 8'h33);
    checkpoint("rep_start");
    i2c_start();
    send_byte(8'h34, 1'b1, "x4_dev");
    send_byte(8'h0E, 1'b1, "x4_reg");
    commit_model(7'h07, 9'h044);
    send_byte(8'h44, 1'b1, "x4_data");
    send_byte(8'h99, 1'b0, "x4_extra");
    exp_err++;
    i2c_stop();
    checkpoint("extra_byte");
    i2c_start();
    send_byte(8'h34, 1'b1, "rst_dev");
    send_byte(8'h06, 1'b1, "rst_reg");
    for (int i = 0; i < 4; i++) bit_out(i == 3, s);
    rst = 1'b1;
    hold(3);
    check("midrst_oe", bus.o_sda_oe, 0);
    check("midrst_cnt", xfer_cnt, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    foreach (mrf[i]) mrf[i] = '0;
    exp_cnt = 0;
    i2c_stop();
    checkpoint("midrst");
    q = 2;
    for (int i = 0; i < 260; i++) frame(8'h34, 8'h04, 8'(i));
    q = 5;
    checkpoint("saturate");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
